// File: rtl/perceptron_train_sequencer_pkg.sv
// Shared types and default sizing for the perceptron training sequencer.
package perceptron_train_sequencer_pkg;

    // Default sizing; the top-level parameters take these unless overridden.
    localparam int DW_DEF        = 32;
    localparam int DEPTH_DEF     = 16;
    localparam int EPW_DEF       = 8;
    localparam int MAX_EPOCH_DEF = 100;

    // Sequencer FSM, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_ABORT  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/perceptron_train_sequencer_sample_mem.sv
// Sample store: DEPTH entries of {x1, x2, t}. One synchronous write port,
// one asynchronous read port. Contents are deliberately not reset so that
// samples survive a reset between runs.
module perceptron_train_sequencer_sample_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [3*DW-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [3*DW-1:0] rdata
);

    logic [3*DW-1:0] mem [DEPTH];

    // Write port: store one sample per strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Perceptron training sequencer: holds the training set, kicks off the
// controller, feeds one registered sample per data request, counts weight
// updates per epoch and completed epochs, and aborts runs that fail to
// converge within MAX_EPOCH epochs.
module perceptron_train_sequencer
    import perceptron_train_sequencer_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int EPW       = EPW_DEF,
    parameter int MAX_EPOCH = MAX_EPOCH_DEF,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [AW:0]    n_samples,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_x1,
    input  logic [DW-1:0]  wr_x2,
    input  logic [DW-1:0]  wr_t,
    output logic           core_start,
    output logic [31:0]    core_n,
    output logic [DW-1:0]  core_x1,
    output logic [DW-1:0]  core_x2,
    output logic [DW-1:0]  core_t,
    input  logic           core_ready,
    input  logic           core_update,
    input  logic           core_reinit,
    input  logic           core_done,
    output logic           core_abort,
    output logic           busy,
    output logic           done,
    output logic           converged,
    output logic           timeout,
    output logic           cfg_err,
    output logic [EPW-1:0] epochs,
    output logic [AW:0]    err_cnt
);

    seq_state_e      state_q, state_d;
    logic [AW:0]     n_q, n_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   x1_q, x1_d, x2_q, x2_d, t_q, t_d;
    logic [EPW-1:0]  epochs_q, epochs_d;
    logic [AW:0]     err_cnt_q, err_cnt_d;
    logic [AW:0]     cur_err_q, cur_err_d;
    logic            converged_q, converged_d;
    logic            timeout_q, timeout_d;
    logic            cfg_err_q, cfg_err_d;

    logic            mem_we;
    logic [AW-1:0]   mem_raddr;
    logic [3*DW-1:0] mem_rdata;
    logic            in_run;
    logic            reinit_eff;
    logic            n_ok;
    logic            ptr_last;
    logic [EPW-1:0]  epoch_inc;
    logic [AW:0]     closing_err;

    assign in_run      = (state_q == ST_RUN);
    // core_done beats core_reinit: a converged run never wraps the pointer.
    assign reinit_eff  = in_run && core_reinit && !core_done;
    assign mem_we      = wr_en && (state_q == ST_IDLE);
    assign mem_raddr   = reinit_eff ? '0 : rd_ptr_q;
    assign n_ok        = (n_samples != '0) && (n_samples <= (AW+1)'(DEPTH));
    assign ptr_last    = ({1'b0, rd_ptr_q} == (n_q - (AW+1)'(1)));
    assign epoch_inc   = epochs_q + EPW'(1);
    // An update coinciding with an epoch boundary belongs to the closing epoch.
    assign closing_err = cur_err_q + (AW+1)'(core_update);

    perceptron_train_sequencer_sample_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata ({wr_x1, wr_x2, wr_t}),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Next-state, data service and counter updates.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_ptr_d    = rd_ptr_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        t_d         = t_q;
        epochs_d    = epochs_q;
        err_cnt_d   = err_cnt_q;
        cur_err_d   = cur_err_q;
        converged_d = converged_q;
        timeout_d   = timeout_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (n_ok) begin
                        state_d     = ST_START;
                        n_d         = n_samples;
                        converged_d = 1'b0;
                        timeout_d   = 1'b0;
                        epochs_d    = '0;
                        err_cnt_d   = '0;
                        cur_err_d   = '0;
                        rd_ptr_d    = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cur_err_d = closing_err;
                // Sample service: an epoch boundary restarts from entry 0.
                if (reinit_eff) begin
                    {x1_d, x2_d, t_d} = mem_rdata;
                    rd_ptr_d = (n_q == (AW+1)'(1)) ? '0 : AW'(1);
                end else if (core_ready) begin
                    {x1_d, x2_d, t_d} = mem_rdata;
                    rd_ptr_d = ptr_last ? '0 : rd_ptr_q + AW'(1);
                end
                // Epoch bookkeeping and run termination.
                if (core_done) begin
                    state_d   = ST_FINISH;
                    epochs_d  = epoch_inc;
                    err_cnt_d = closing_err;
                end else if (core_reinit) begin
                    epochs_d  = epoch_inc;
                    err_cnt_d = closing_err;
                    cur_err_d = '0;
                    if (epoch_inc == EPW'(MAX_EPOCH)) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_FINISH: begin
                converged_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            rd_ptr_q    <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            t_q         <= '0;
            epochs_q    <= '0;
            err_cnt_q   <= '0;
            cur_err_q   <= '0;
            converged_q <= 1'b0;
            timeout_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_ptr_q    <= rd_ptr_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            t_q         <= t_d;
            epochs_q    <= epochs_d;
            err_cnt_q   <= err_cnt_d;
            cur_err_q   <= cur_err_d;
            converged_q <= converged_d;
            timeout_q   <= timeout_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign core_start = (state_q == ST_START);
    assign core_abort = (state_q == ST_ABORT);
    assign done       = (state_q == ST_ABORT) || (state_q == ST_FINISH);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign core_n     = 32'(n_q);
    assign core_x1    = x1_q;
    assign core_x2    = x2_q;
    assign core_t     = t_q;
    assign converged  = converged_q;
    assign timeout    = timeout_q;
    assign cfg_err    = cfg_err_q;
    assign epochs     = epochs_q;
    assign err_cnt    = err_cnt_q;

endmodule
